// File: rtl/cp0_commit_if.sv
// ============================================================================
//  Module      : cp0_commit_if
//  Description : Commit-stage / CP0 / frontend bundle for cp0_commit_ctrl.
//                slave  = the commit controller view
//                master = the surrounding pipeline / cp0 / frontend view
//  Signals     : sN_* slot inputs (N=1 older, N=2 younger), has_int/epc_res
//                from cp0, pms_* event port to cp0, gated mtc0 enables,
//                commit/replay/stall to the commit stage, redirect/flush
//                handshake to the frontend.
//  Config      : CP0_COMMIT_STATS_EN adds exc_cnt/int_cnt/eret_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_commit_if;
    // commit slots
    logic        s1_valid,    s2_valid;
    logic        s1_ex,       s2_ex;
    logic [4:0]  s1_excode,   s2_excode;
    logic        s1_bd,       s2_bd;
    logic [31:0] s1_pc,       s2_pc;
    logic [31:0] s1_badvaddr, s2_badvaddr;
    logic        s1_eret,     s2_eret;
    logic        s1_mtc0_we,  s2_mtc0_we;
    logic [7:0]  s1_c0_addr,  s2_c0_addr;
    // from cp0
    logic        has_int;
    logic [31:0] epc_res;
    // to cp0
    logic        pms_ex;
    logic [4:0]  ex_type;
    logic        pms_bd;
    logic [31:0] pms_pc;
    logic [31:0] pms_badvaddr;
    logic        pms_eret;
    logic        inst1_mtc0_we, inst2_mtc0_we;
    // to commit stage
    logic        commit1_ok, commit2_ok, replay2, stall_commit;
    // frontend
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
`ifdef CP0_COMMIT_STATS_EN
    logic [31:0] exc_cnt, int_cnt, eret_cnt;
`endif

    modport slave (
        input  s1_valid, s1_ex, s1_excode, s1_bd, s1_pc, s1_badvaddr, s1_eret,
               s1_mtc0_we, s1_c0_addr,
               s2_valid, s2_ex, s2_excode, s2_bd, s2_pc, s2_badvaddr, s2_eret,
               s2_mtc0_we, s2_c0_addr,
               has_int, epc_res, redirect_ready,
        output pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret,
               inst1_mtc0_we, inst2_mtc0_we,
               commit1_ok, commit2_ok, replay2, stall_commit,
               redirect_valid, redirect_pc, flush
`ifdef CP0_COMMIT_STATS_EN
        , output exc_cnt, int_cnt, eret_cnt
`endif
    );

    modport master (
        output s1_valid, s1_ex, s1_excode, s1_bd, s1_pc, s1_badvaddr, s1_eret,
               s1_mtc0_we, s1_c0_addr,
               s2_valid, s2_ex, s2_excode, s2_bd, s2_pc, s2_badvaddr, s2_eret,
               s2_mtc0_we, s2_c0_addr,
               has_int, epc_res, redirect_ready,
        input  pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret,
               inst1_mtc0_we, inst2_mtc0_we,
               commit1_ok, commit2_ok, replay2, stall_commit,
               redirect_valid, redirect_pc, flush
`ifdef CP0_COMMIT_STATS_EN
        , input exc_cnt, int_cnt, eret_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/cp0_commit_ctrl.sv
// ============================================================================
//  Module      : cp0_commit_ctrl
//  Description : Commit-side sequencer for the dual-issue CP0. Selects at most
//                one interrupt/exception/ERET event per cycle from the two
//                commit slots (slot1 older), gates mtc0 writes, drives the cp0
//                single-event port and then runs a redirect + flush sequence
//                towards the frontend.
//  Ports       : cp0_clk  - clock
//                reset    - synchronous, active-high
//                bus      - cp0_commit_if.slave (slots, cp0 port, redirect)
//  Config      : CP0_COMMIT_STATS_EN adds 32-bit wrapping event counters
//                exc_cnt / int_cnt / eret_cnt on the interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_commit_ctrl #(
    parameter logic [31:0] EX_VECTOR    = 32'hBFC00380,
    parameter int unsigned INT_SETTLE   = 2,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input wire          cp0_clk,
    input wire          reset,
    cp0_commit_if.slave bus
);

    // CP0 {rd,sel} addresses of interest
    localparam logic [7:0] c_ADDR_COMPARE = 8'b01011_000;
    localparam logic [7:0] c_ADDR_STATUS  = 8'b01100_000;
    localparam logic [7:0] c_ADDR_CAUSE   = 8'b01101_000;
    localparam logic [7:0] c_ADDR_EPC     = 8'b01110_000;

    localparam logic [3:0] c_INT_SETTLE = 4'(INT_SETTLE);
    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_drain_cnt, w_drain_nxt;
    logic [3:0]  r_blk_cnt;
    logic [31:0] r_redirect_pc;

    logic        w_pms_ex, w_pms_bd, w_pms_eret;
    logic [4:0]  w_ex_type;
    logic [31:0] w_pms_pc, w_pms_badvaddr;
    logic        w_m1, w_m2, w_commit1, w_commit2, w_replay2;
    logic        w_stall, w_redirect_valid, w_flush;
    logic        w_event, w_event_ex, w_event_int;
    logic        w_blk_load;

    // Writes to these registers can change whether an interrupt is pending,
    // so the interrupt input is not trusted until cp0 has settled.
    function automatic logic f_int_reg(input logic [7:0] addr);
        return (addr == c_ADDR_STATUS) || (addr == c_ADDR_CAUSE) ||
               (addr == c_ADDR_COMPARE);
    endfunction

    wire w_int_take = bus.has_int && bus.s1_valid && (r_blk_cnt == 4'd0);
    wire w_s1_ex    = bus.s1_valid && bus.s1_ex;
    wire w_s1_eret  = bus.s1_valid && bus.s1_eret;
    wire w_s2_ex    = bus.s2_valid && bus.s2_ex;
    wire w_s2_eret  = bus.s2_valid && bus.s2_eret;
    // slot1 writing EPC in the same cycle as a slot2 ERET: the ERET would read
    // a stale epc_res, so slot2 is sent round again once the write has landed.
    wire w_epc_hazard = bus.s1_valid && bus.s1_mtc0_we &&
                        (bus.s1_c0_addr == c_ADDR_EPC);

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_pms_ex         = 1'b0;
        w_ex_type        = 5'd0;
        w_pms_bd         = 1'b0;
        w_pms_pc         = 32'd0;
        w_pms_badvaddr   = 32'd0;
        w_pms_eret       = 1'b0;
        w_m1             = 1'b0;
        w_m2             = 1'b0;
        w_commit1        = 1'b0;
        w_commit2        = 1'b0;
        w_replay2        = 1'b0;
        w_stall          = 1'b0;
        w_redirect_valid = 1'b0;
        w_flush          = 1'b0;
        w_event          = 1'b0;
        w_event_ex       = 1'b0;
        w_event_int      = 1'b0;
        w_state_nxt      = r_state;
        w_drain_nxt      = r_drain_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_int_take) begin
                    // Interrupt is taken on slot1; nothing retires.
                    w_pms_ex    = 1'b1;
                    w_ex_type   = 5'd0;
                    w_pms_bd    = bus.s1_bd;
                    w_pms_pc    = bus.s1_pc;
                    w_event     = 1'b1;
                    w_event_ex  = 1'b1;
                    w_event_int = 1'b1;
                end else if (w_s1_ex) begin
                    w_pms_ex       = 1'b1;
                    w_ex_type      = bus.s1_excode;
                    w_pms_bd       = bus.s1_bd;
                    w_pms_pc       = bus.s1_pc;
                    w_pms_badvaddr = bus.s1_badvaddr;
                    w_event        = 1'b1;
                    w_event_ex     = 1'b1;
                end else if (w_s1_eret) begin
                    w_pms_eret = 1'b1;
                    w_commit1  = 1'b1;
                    w_event    = 1'b1;
                end else begin
                    // slot1 retires normally from here on
                    w_commit1 = bus.s1_valid;
                    w_m1      = bus.s1_valid && bus.s1_mtc0_we;
                    if (w_s2_ex) begin
                        w_pms_ex       = 1'b1;
                        w_ex_type      = bus.s2_excode;
                        w_pms_bd       = bus.s2_bd;
                        w_pms_pc       = bus.s2_pc;
                        w_pms_badvaddr = bus.s2_badvaddr;
                        w_event        = 1'b1;
                        w_event_ex     = 1'b1;
                    end else if (w_s2_eret && w_epc_hazard) begin
                        w_replay2 = 1'b1;
                    end else if (w_s2_eret) begin
                        w_pms_eret = 1'b1;
                        w_commit2  = 1'b1;
                        w_event    = 1'b1;
                    end else begin
                        w_commit2 = bus.s2_valid;
                        w_m2      = bus.s2_valid && bus.s2_mtc0_we;
                    end
                end
                if (w_event) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                w_redirect_valid = 1'b1;
                w_flush          = 1'b1;
                w_stall          = 1'b1;
                if (bus.redirect_ready) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = c_DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                w_flush = 1'b1;
                w_stall = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_drain_nxt = r_drain_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_blk_load = (w_m1 && f_int_reg(bus.s1_c0_addr)) ||
                        (w_m2 && f_int_reg(bus.s2_c0_addr));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Redirect target and interrupt block counter
    // ------------------------------------------------------------------------
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            r_redirect_pc <= 32'd0;
            r_blk_cnt     <= 4'd0;
        end else begin
            // epc_res is sampled in the event cycle, before cp0 updates
            if (w_event) begin
                r_redirect_pc <= w_event_ex ? EX_VECTOR : bus.epc_res;
            end
            if (w_blk_load) begin
                r_blk_cnt <= c_INT_SETTLE;
            end else if (r_blk_cnt != 4'd0) begin
                r_blk_cnt <= r_blk_cnt - 4'd1;
            end
        end
    end

`ifdef CP0_COMMIT_STATS_EN
    logic [31:0] r_exc_cnt, r_int_cnt, r_eret_cnt;

    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            r_exc_cnt  <= 32'd0;
            r_int_cnt  <= 32'd0;
            r_eret_cnt <= 32'd0;
        end else begin
            if (w_event && w_event_ex && !w_event_int) r_exc_cnt  <= r_exc_cnt + 32'd1;
            if (w_event && w_event_int)               r_int_cnt  <= r_int_cnt + 32'd1;
            if (w_event && !w_event_ex)               r_eret_cnt <= r_eret_cnt + 32'd1;
        end
    end

    assign bus.exc_cnt  = r_exc_cnt;
    assign bus.int_cnt  = r_int_cnt;
    assign bus.eret_cnt = r_eret_cnt;
`endif

    assign bus.pms_ex         = w_pms_ex;
    assign bus.ex_type        = w_ex_type;
    assign bus.pms_bd         = w_pms_bd;
    assign bus.pms_pc         = w_pms_pc;
    assign bus.pms_badvaddr   = w_pms_badvaddr;
    assign bus.pms_eret       = w_pms_eret;
    assign bus.inst1_mtc0_we  = w_m1;
    assign bus.inst2_mtc0_we  = w_m2;
    assign bus.commit1_ok     = w_commit1;
    assign bus.commit2_ok     = w_commit2;
    assign bus.replay2        = w_replay2;
    assign bus.stall_commit   = w_stall;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = w_flush;

endmodule

`default_nettype wire

// File: tb/tb_cp0_commit_ctrl.sv
// ============================================================================
//  Module      : tb_cp0_commit_ctrl
//  Description : Self-checking bench for cp0_commit_ctrl. Each scenario is a
//                table of per-cycle inputs with the expected outputs for that
//                cycle; expectations go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cp0_commit_ctrl;

    logic cp0_clk = 1'b0;
    logic reset;
    always #5 cp0_clk = ~cp0_clk;

    cp0_commit_if bus ();

    cp0_commit_ctrl #(
        .EX_VECTOR   (32'hBFC00380),
        .INT_SETTLE  (2),
        .DRAIN_CYCLES(2)
    ) dut (
        .cp0_clk(cp0_clk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct packed {
        logic        v, ex;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc, bad;
        logic        eret, we;
        logic [7:0]  addr;
    } slot_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  et;
        logic        bd;
        logic [31:0] pc, bad;
        logic        eret, m1, m2, c1, c2, rp, st, rv, fl;
        logic [31:0] rpc;
    } obs_t;

    typedef struct {
        logic        rst;
        slot_t       s1, s2;
        logic        hi, rdy;
        logic [31:0] epc;
        obs_t        exp;
    } cyc_t;

    localparam slot_t Z = '0;
    localparam logic [31:0] VEC = 32'hBFC00380;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic slot_t sl(logic v, logic ex, logic [4:0] code, logic bd,
                                 logic [31:0] pc, logic [31:0] bad, logic eret,
                                 logic we, logic [7:0] addr);
        slot_t s;
        s.v = v; s.ex = ex; s.code = code; s.bd = bd; s.pc = pc; s.bad = bad;
        s.eret = eret; s.we = we; s.addr = addr;
        return s;
    endfunction

    // IDLE-state expectation: cp0 port, mtc0 gates, commit/replay
    function automatic obs_t mk_ev(logic ex, logic [4:0] et, logic bd, logic [31:0] pc,
                                   logic [31:0] bad, logic eret, logic m1, logic m2,
                                   logic c1, logic c2, logic rp, logic [31:0] rpc);
        obs_t o = '0;
        o.ex = ex; o.et = et; o.bd = bd; o.pc = pc; o.bad = bad; o.eret = eret;
        o.m1 = m1; o.m2 = m2; o.c1 = c1; o.c2 = c2; o.rp = rp; o.rpc = rpc;
        return o;
    endfunction

    // REDIRECT/DRAIN expectation: flush and stall held, cp0 port quiet
    function automatic obs_t mk_seq(logic rv, logic [31:0] rpc);
        obs_t o = '0;
        o.st = 1'b1; o.fl = 1'b1; o.rv = rv; o.rpc = rpc;
        return o;
    endfunction

    function automatic cyc_t cy(logic rst, slot_t s1, slot_t s2, logic hi, logic rdy,
                                logic [31:0] epc, obs_t exp);
        cyc_t c;
        c.rst = rst; c.s1 = s1; c.s2 = s2; c.hi = hi; c.rdy = rdy; c.epc = epc; c.exp = exp;
        return c;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.ex = bus.pms_ex; o.et = bus.ex_type; o.bd = bus.pms_bd; o.pc = bus.pms_pc;
        o.bad = bus.pms_badvaddr; o.eret = bus.pms_eret;
        o.m1 = bus.inst1_mtc0_we; o.m2 = bus.inst2_mtc0_we;
        o.c1 = bus.commit1_ok; o.c2 = bus.commit2_ok; o.rp = bus.replay2;
        o.st = bus.stall_commit; o.rv = bus.redirect_valid; o.fl = bus.flush;
        o.rpc = bus.redirect_pc;
        return o;
    endfunction

    task automatic apply(cyc_t c);
        reset              = c.rst;
        bus.s1_valid       = c.s1.v;    bus.s2_valid    = c.s2.v;
        bus.s1_ex          = c.s1.ex;   bus.s2_ex       = c.s2.ex;
        bus.s1_excode      = c.s1.code; bus.s2_excode   = c.s2.code;
        bus.s1_bd          = c.s1.bd;   bus.s2_bd       = c.s2.bd;
        bus.s1_pc          = c.s1.pc;   bus.s2_pc       = c.s2.pc;
        bus.s1_badvaddr    = c.s1.bad;  bus.s2_badvaddr = c.s2.bad;
        bus.s1_eret        = c.s1.eret; bus.s2_eret     = c.s2.eret;
        bus.s1_mtc0_we     = c.s1.we;   bus.s2_mtc0_we  = c.s2.we;
        bus.s1_c0_addr     = c.s1.addr; bus.s2_c0_addr  = c.s2.addr;
        bus.has_int        = c.hi;
        bus.redirect_ready = c.rdy;
        bus.epc_res        = c.epc;
    endtask

    task automatic test_reset();
        cyc_t t[$];
        obs_t got, e;
        t.push_back(cy(1, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000000, 0, 0, 1, 8'h40), Z, 0, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000004, 0, 0, 0, 0),
                       sl(1, 0, 0, 0, 32'h80000008, 0, 0, 1, 8'h48), 0, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_s1_exception();
        cyc_t  t[$];
        obs_t  got, e;
        slot_t s1x = sl(1, 1, 5'd4, 0, 32'hBFC00100, 32'h00001234, 0, 1, 8'h60);
        slot_t s2p = sl(1, 0, 0, 0, 32'hBFC00104, 0, 0, 1, 8'h40);
        t.push_back(cy(0, s1x, s2p, 0, 0, 0,
                       mk_ev(1, 5'd4, 0, 32'hBFC00100, 32'h00001234, 0, 0, 0, 0, 0, 0, 0)));
        // pending interrupt and live slots must be ignored while sequencing
        t.push_back(cy(0, s1x, s2p, 1, 1, 0, mk_seq(1, VEC)));
        t.push_back(cy(0, s1x, s2p, 1, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, s1x, s2p, 1, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL s1_exception[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_s2_exception();
        cyc_t t[$];
        obs_t got, e;
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000008, 0, 0, 1, 8'h40),
                       sl(1, 1, 5'd5, 1, 32'h80000010, 32'hDEAD0000, 0, 1, 8'h40), 0, 0, 0,
                       mk_ev(1, 5'd5, 1, 32'h80000010, 32'hDEAD0000, 0, 1, 0, 1, 0, 0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 1, 0, mk_seq(1, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL s2_exception[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_interrupt();
        cyc_t  t[$];
        obs_t  got, e;
        slot_t s1v = sl(1, 0, 0, 0, 32'h80000100, 0, 0, 0, 0);
        // no slot1 -> no interrupt even though one is pending
        t.push_back(cy(0, Z, sl(1, 0, 0, 0, 32'h80000104, 0, 0, 0, 0), 1, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, VEC)));
        t.push_back(cy(0, sl(1, 0, 0, 1, 32'h80000200, 0, 0, 1, 8'h60),
                       sl(1, 0, 0, 0, 32'h80000204, 0, 0, 0, 0), 1, 0, 0,
                       mk_ev(1, 5'd0, 1, 32'h80000200, 0, 0, 0, 0, 0, 0, 0, VEC)));
        t.push_back(cy(0, s1v, Z, 1, 1, 0, mk_seq(1, VEC)));
        t.push_back(cy(0, s1v, Z, 1, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, s1v, Z, 1, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL interrupt[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_int_block();
        cyc_t t[$];
        obs_t got, e;
        // slot2 mtc0 COMPARE blocks for two cycles
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h800002F0, 0, 0, 0, 0),
                       sl(1, 0, 0, 0, 32'h800002F4, 0, 0, 1, 8'h58), 0, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, VEC)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h800002F8, 0, 0, 0, 0), Z, 1, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        // slot1 mtc0 STATUS: blocked two cycles, taken on the third
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000300, 0, 0, 1, 8'h60), Z, 0, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, VEC)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000304, 0, 0, 0, 0), Z, 1, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, VEC)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000308, 0, 0, 0, 0), Z, 1, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, VEC)));
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h8000030C, 0, 0, 0, 0), Z, 1, 0, 0,
                       mk_ev(1, 5'd0, 0, 32'h8000030C, 0, 0, 0, 0, 0, 0, 0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 1, 0, mk_seq(1, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL int_block[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_eret_hazard();
        cyc_t  t[$];
        obs_t  got, e;
        slot_t eret2 = sl(1, 0, 0, 0, 0, 0, 1, 0, 0);
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000400, 0, 0, 1, 8'h70), eret2, 0, 0,
                       32'h80000ABC, mk_ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, VEC)));
        // replayed ERET sees the EPC value written by the mtc0
        t.push_back(cy(0, Z, eret2, 0, 0, 32'h80001000,
                       mk_ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 1, 32'h80001000, mk_seq(1, 32'h80001000)));
        t.push_back(cy(0, Z, Z, 0, 0, 32'h80001000, mk_seq(0, 32'h80001000)));
        t.push_back(cy(0, Z, Z, 0, 0, 32'h80001000, mk_seq(0, 32'h80001000)));
        t.push_back(cy(0, Z, Z, 0, 0, 32'h80001000,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80001000)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL eret_hazard[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        cyc_t t[$];
        obs_t got, e;
        t.push_back(cy(0, sl(1, 0, 0, 0, 0, 0, 1, 0, 0),
                       sl(1, 0, 0, 0, 32'h80000504, 0, 0, 1, 8'h60), 0, 0, 32'h80002000,
                       mk_ev(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h80001000)));
        for (int k = 0; k < 5; k++)
            t.push_back(cy(0, Z, Z, 0, 0, 32'h80002000, mk_seq(1, 32'h80002000)));
        t.push_back(cy(0, Z, Z, 0, 1, 32'h80002000, mk_seq(1, 32'h80002000)));
        t.push_back(cy(0, Z, Z, 0, 0, 32'h80002000, mk_seq(0, 32'h80002000)));
        t.push_back(cy(0, Z, Z, 0, 0, 32'h80002000, mk_seq(0, 32'h80002000)));
        // new event on the first IDLE cycle after the drain
        t.push_back(cy(0, sl(1, 1, 5'd10, 0, 32'h80000600, 0, 0, 0, 0), Z, 0, 0, 32'h80002000,
                       mk_ev(1, 5'd10, 0, 32'h80000600, 0, 0, 0, 0, 0, 0, 0, 32'h80002000)));
        t.push_back(cy(0, Z, Z, 0, 1, 0, mk_seq(1, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VEC)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        cyc_t t[$];
        obs_t got, e;
        t.push_back(cy(0, sl(1, 1, 5'd12, 0, 32'h80000700, 0, 0, 0, 0), Z, 0, 0, 0,
                       mk_ev(1, 5'd12, 0, 32'h80000700, 0, 0, 0, 0, 0, 0, 0, VEC)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_seq(1, VEC)));
        t.push_back(cy(1, Z, Z, 0, 0, 0, mk_seq(1, VEC)));
        // invalid slot2 carrying ex/eret/mtc0 must be ignored entirely
        t.push_back(cy(0, sl(1, 0, 0, 0, 32'h80000800, 0, 0, 0, 0),
                       sl(0, 1, 5'd3, 1, 32'h80000804, 32'hFFFF, 1, 1, 8'h60), 0, 0, 0,
                       mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
        t.push_back(cy(0, Z, Z, 0, 0, 0, mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]);
            sb.push_back(t[i].exp);
            @(negedge cp0_clk);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h exp %h", i, got, e);
            end
            @(posedge cp0_clk); #1;
        end
    endtask

    initial begin
        apply(cy(1, Z, Z, 0, 0, 0, '0));
        repeat (2) @(posedge cp0_clk);
        #1;
        test_reset();
        test_s1_exception();
        test_s2_exception();
        test_interrupt();
        test_int_block();
        test_eret_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
